// File: rtl/id_scoreboard_pkg.sv
// Shared constants and types for the ID-stage operand collector and its
// long-latency result scoreboard.
package id_scoreboard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [7:0]            EXE_NOP_OP   = 8'b0000_0000;
   localparam logic [2:0]            EXE_RES_NOP  = 3'b000;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

   typedef struct packed {
      logic [7:0]            aluop;
      logic [2:0]            alusel;
      logic [REG_ADDR_W-1:0] wd;
      logic                  wreg;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{aluop: EXE_NOP_OP, alusel: EXE_RES_NOP,
                                  wd: NOP_REG_ADDR, wreg: 1'b0};

endpackage

// File: rtl/id_scoreboard_fwd_mux.sv
// Operand source select: immediate, hard-wired r0, prioritised forwarding
// ports (port 0 = youngest) or register file read data.
module fwd_mux
   import id_scoreboard_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_FWD = 2
) (
   input  logic                           read_i,
   input  logic [REG_ADDR_W-1:0]          addr_i,
   input  logic [DATA_W-1:0]              imm_i,
   input  logic [DATA_W-1:0]              rf_data_i,
   input  logic [NUM_FWD-1:0]             fwd_we_i,
   input  logic [REG_ADDR_W*NUM_FWD-1:0]  fwd_addr_i,
   input  logic [DATA_W*NUM_FWD-1:0]      fwd_data_i,
   output logic [DATA_W-1:0]              data_o
);

   logic              hit;
   logic [DATA_W-1:0] fwd_data;

   always_comb begin
      hit      = 1'b0;
      fwd_data = '0;
      // Walk from the oldest port down so the youngest match overrides.
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_we_i[k] && fwd_addr_i[REG_ADDR_W*k +: REG_ADDR_W] == addr_i) begin
            hit      = 1'b1;
            fwd_data = fwd_data_i[DATA_W*k +: DATA_W];
         end
      end

      if (!read_i) begin
         data_o = imm_i;
      end else if (addr_i == '0) begin
         data_o = '0;
      end else if (hit) begin
         data_o = fwd_data;
      end else begin
         data_o = rf_data_i;
      end
   end

endmodule

// File: rtl/id_scoreboard.sv
// Operand-collect and issue stage: countdown scoreboard for long-latency
// results, operand forwarding select and a valid/ready ID/EX output slot.
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_FWD = 2,
   parameter int LAT_W   = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic                          rs_read_i,
   input  logic                          rt_read_i,
   input  logic [4:0]                    rs_addr_i,
   input  logic [4:0]                    rt_addr_i,
   input  logic [DATA_W-1:0]             imm_i,
   input  logic                          wreg_i,
   input  logic [4:0]                    wd_i,
   input  logic [LAT_W-1:0]              lat_i,
   input  logic [7:0]                    aluop_i,
   input  logic [2:0]                    alusel_i,
   input  logic [DATA_W-1:0]             rs_data_i,
   input  logic [DATA_W-1:0]             rt_data_i,
   input  logic [NUM_FWD-1:0]            fwd_we_i,
   input  logic [5*NUM_FWD-1:0]          fwd_addr_i,
   input  logic [DATA_W*NUM_FWD-1:0]     fwd_data_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DATA_W-1:0]             reg1_o,
   output logic [DATA_W-1:0]             reg2_o,
   output logic [7:0]                    aluop_o,
   output logic [2:0]                    alusel_o,
   output logic [4:0]                    wd_o,
   output logic                          wreg_o,
   output logic                          hazard_o
);

   logic [LAT_W-1:0]  cnt_q [NUM_REGS];
   logic [LAT_W-1:0]  cnt_d [NUM_REGS];
   logic              hazard;
   logic              adv;
   logic              in_ready;
   logic              accept;
   logic [DATA_W-1:0] reg1_mux, reg2_mux;
   logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic              out_valid_q, out_valid_d;

   function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v, input logic en);
      return (en && v != '0) ? v - LAT_W'(1) : v;
   endfunction

   function automatic logic [LAT_W-1:0] lat_max(input logic [LAT_W-1:0] a, input logic [LAT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign adv = out_ready_i;

   always_comb begin
      hazard = (rs_read_i && cnt_q[rs_addr_i] != '0) ||
               (rt_read_i && cnt_q[rt_addr_i] != '0);
   end

   assign in_ready   = !flush_i && !hazard && (!out_valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready;
   assign in_ready_o = in_ready;
   assign hazard_o   = in_valid_i && hazard;

   fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rs_mux (
      .read_i     (rs_read_i),
      .addr_i     (rs_addr_i),
      .imm_i      (imm_i),
      .rf_data_i  (rs_data_i),
      .fwd_we_i   (fwd_we_i),
      .fwd_addr_i (fwd_addr_i),
      .fwd_data_i (fwd_data_i),
      .data_o     (reg1_mux)
   );

   fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rt_mux (
      .read_i     (rt_read_i),
      .addr_i     (rt_addr_i),
      .imm_i      (imm_i),
      .rf_data_i  (rt_data_i),
      .fwd_we_i   (fwd_we_i),
      .fwd_addr_i (fwd_addr_i),
      .fwd_data_i (fwd_data_i),
      .data_o     (reg2_mux)
   );

   // A new issue never shortens a pending count, which keeps WAW ordering safe.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = sat_dec(cnt_q[r], adv);
         if (accept && wreg_i && wd_i == REG_ADDR_W'(r)) begin
            cnt_d[r] = lat_max(cnt_d[r], lat_i);
         end
      end
      cnt_d[0] = '0;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      reg1_d      = reg1_q;
      reg2_d      = reg2_q;
      ctrl_d      = ctrl_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
         ctrl_d.wreg = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         reg1_d      = reg1_mux;
         reg2_d      = reg2_mux;
         ctrl_d      = '{aluop: aluop_i, alusel: alusel_i, wd: wd_i, wreg: wreg_i};
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // ---- ID/EX boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         out_valid_q <= 1'b0;
         reg1_q      <= '0;
         reg2_q      <= '0;
         ctrl_q      <= CTRL_NOP;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         out_valid_q <= out_valid_d;
         reg1_q      <= reg1_d;
         reg2_q      <= reg2_d;
         ctrl_q      <= ctrl_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign reg1_o      = reg1_q;
   assign reg2_o      = reg2_q;
   assign aluop_o     = ctrl_q.aluop;
   assign alusel_o    = ctrl_q.alusel;
   assign wd_o        = ctrl_q.wd;
   assign wreg_o      = ctrl_q.wreg;

endmodule

// File: tb/tb_id_scoreboard.sv
// Randomised and directed bench for id_scoreboard with a queue-based
// scoreboard and a time-stamp reference model of register readiness.
module tb_id_scoreboard;
   import id_scoreboard_pkg::*;

   localparam int DATA_W  = 32;
   localparam int NUM_FWD = 2;
   localparam int LAT_W   = 3;
   localparam int SLOT_W  = 2*DATA_W + 8 + 3 + 5 + 1;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      flush_i, in_valid_i, in_ready_o;
   logic                      rs_read_i, rt_read_i;
   logic [4:0]                rs_addr_i, rt_addr_i;
   logic [DATA_W-1:0]         imm_i;
   logic                      wreg_i;
   logic [4:0]                wd_i;
   logic [LAT_W-1:0]          lat_i;
   logic [7:0]                aluop_i;
   logic [2:0]                alusel_i;
   logic [DATA_W-1:0]         rs_data_i, rt_data_i;
   logic [NUM_FWD-1:0]        fwd_we_i;
   logic [5*NUM_FWD-1:0]      fwd_addr_i;
   logic [DATA_W*NUM_FWD-1:0] fwd_data_i;
   logic                      out_valid_o, out_ready_i;
   logic [DATA_W-1:0]         reg1_o, reg2_o;
   logic [7:0]                aluop_o;
   logic [2:0]                alusel_o;
   logic [4:0]                wd_o;
   logic                      wreg_o, hazard_o;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: a register is readable once the number of advancing
   // edges seen so far reaches the time stamp recorded when it was issued.
   int  ready_at [32];
   int  adv_total = 0;
   bit  ov_m = 0, acc_m = 0, rdy_m = 0, flush_m = 0, wreg_m = 0;
   int  wd_m = 0, lat_m = 0;
   logic [SLOT_W-1:0] exp_q [$];

   id_scoreboard #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .LAT_W(LAT_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .rs_read_i(rs_read_i), .rt_read_i(rt_read_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
      .imm_i(imm_i), .wreg_i(wreg_i), .wd_i(wd_i), .lat_i(lat_i), .aluop_i(aluop_i),
      .alusel_i(alusel_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .fwd_we_i(fwd_we_i),
      .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .reg1_o(reg1_o), .reg2_o(reg2_o), .aluop_o(aluop_o),
      .alusel_o(alusel_o), .wd_o(wd_o), .wreg_o(wreg_o), .hazard_o(hazard_o)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit busy(input logic [4:0] a);
      return a != 5'd0 && ready_at[a] > adv_total;
   endfunction

   function automatic logic [DATA_W-1:0] sel_ref(input logic rd, input logic [4:0] a,
                                                 input logic [DATA_W-1:0] rf);
      if (!rd) return imm_i;
      if (a == 5'd0) return '0;
      for (int k = 0; k < NUM_FWD; k++)
         if (fwd_we_i[k] && fwd_addr_i[5*k +: 5] == a) return fwd_data_i[DATA_W*k +: DATA_W];
      return rf;
   endfunction

   function automatic logic [SLOT_W-1:0] slot_now();
      return {reg1_o, reg2_o, aluop_o, alusel_o, wd_o, wreg_o};
   endfunction

   // Model: evaluate the handshake mid-cycle, record expected slot contents.
   always @(negedge clk) begin
      if (!rst) begin
         bit hz, rdy;
         hz  = (rs_read_i && busy(rs_addr_i)) || (rt_read_i && busy(rt_addr_i));
         rdy = !flush_i && !hz && (!ov_m || out_ready_i);
         check("hazard_o", hazard_o, in_valid_i && hz);
         check("in_ready_o", in_ready_o, rdy);
         check("out_valid_o", out_valid_o, ov_m);
         acc_m = in_valid_i && rdy;
         if (acc_m)
            exp_q.push_back({sel_ref(rs_read_i, rs_addr_i, rs_data_i),
                             sel_ref(rt_read_i, rt_addr_i, rt_data_i),
                             aluop_i, alusel_i, wd_i, wreg_i});
         rdy_m = out_ready_i; flush_m = flush_i; wreg_m = wreg_i;
         wd_m = int'(wd_i); lat_m = int'(lat_i);
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) ready_at[r] = 0;
         adv_total = 0; ov_m = 0; acc_m = 0; rdy_m = 0; flush_m = 0;
      end else begin
         if (rdy_m) adv_total++;
         if (acc_m && wreg_m && wd_m != 0 && adv_total + lat_m > ready_at[wd_m])
            ready_at[wd_m] = adv_total + lat_m;
         ov_m = flush_m ? 1'b0 : acc_m ? 1'b1 : rdy_m ? 1'b0 : ov_m;
      end
   end

   // Monitor: the presented slot must match the queue head until it leaves.
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else if (out_valid_o) begin
         if (exp_q.size() == 0) begin
            check("slot_expected", 1'b1, 1'b0);
         end else begin
            check("slot", slot_now(), exp_q[0]);
            if (out_ready_i || flush_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      in_valid_i = 0; flush_i = 0; out_ready_i = 1;
      rs_read_i = 0; rt_read_i = 0; rs_addr_i = 0; rt_addr_i = 0;
      imm_i = '0; wreg_i = 0; wd_i = 0; lat_i = 0; aluop_i = 8'h00; alusel_i = 3'd0;
      rs_data_i = 32'hDEAD_0001; rt_data_i = 32'hDEAD_0002;
      fwd_we_i = '0; fwd_addr_i = '0; fwd_data_i = '0;
   endtask

   task automatic set_fwd(input int k, input logic we, input logic [4:0] a, input logic [DATA_W-1:0] d);
      fwd_we_i[k] = we;
      fwd_addr_i[5*k +: 5] = a;
      fwd_data_i[DATA_W*k +: DATA_W] = d;
   endtask

   task automatic instr(input logic rsr, input logic [4:0] rs, input logic rtr, input logic [4:0] rt,
                        input logic wr, input logic [4:0] wd, input int lat, input logic [7:0] op);
      in_valid_i = 1; rs_read_i = rsr; rs_addr_i = rs; rt_read_i = rtr; rt_addr_i = rt;
      wreg_i = wr; wd_i = wd; lat_i = LAT_W'(lat); aluop_i = op; alusel_i = 3'd1;
      imm_i = 32'h0000_0055;
   endtask

   // Hold the current instruction until accepted; count scoreboard stalls.
   task automatic wait_issue(input string nm, input int want);
      int n = 0;
      bit acc = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (in_ready_o) begin acc = 1; break; end
         if (hazard_o) n++;
      end
      check({nm, "_issued"}, acc, 1'b1);
      check({nm, "_stalls"}, n, want);
      step();
   endtask

   task automatic rand_cycle();
      in_valid_i = $urandom_range(0, 3) != 0;
      rs_read_i = $urandom_range(0, 4) != 0; rt_read_i = $urandom_range(0, 4) != 0;
      rs_addr_i = 5'($urandom_range(0, 7)); rt_addr_i = 5'($urandom_range(0, 7));
      imm_i = $urandom; wreg_i = 1'($urandom_range(0, 1)); wd_i = 5'($urandom_range(0, 7));
      lat_i = LAT_W'($urandom_range(0, 3)); aluop_i = 8'($urandom); alusel_i = 3'($urandom);
      rs_data_i = $urandom; rt_data_i = $urandom;
      for (int k = 0; k < NUM_FWD; k++)
         set_fwd(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      out_ready_i = $urandom_range(0, 3) != 0;
      flush_i = $urandom_range(0, 19) == 0;
   endtask

   initial begin
      logic [SLOT_W-1:0] snap;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid_o, 1'b0);
      check("rst_aluop", aluop_o, EXE_NOP_OP);
      check("rst_alusel", alusel_o, EXE_RES_NOP);
      check("rst_reg1_reg2_wd_wreg", {reg1_o, reg2_o, wd_o, wreg_o}, '0);
      rst = 0;
      step();

      // ori r1 (lat 0) then or r2,r1,r1 forwarded from port 0, back to back.
      instr(1, 5'd0, 0, 5'd0, 1, 5'd1, 0, 8'h0D);
      @(negedge clk); check("ori_ready", in_ready_o, 1'b1);
      step();
      instr(1, 5'd1, 1, 5'd1, 1, 5'd2, 0, 8'h25);
      set_fwd(0, 1, 5'd1, 32'h1234);
      @(negedge clk); check("or_b2b_ready", in_ready_o, 1'b1);
      step(); idle();
      check("or_reg1", reg1_o, 32'h1234);
      check("or_reg2", reg2_o, 32'h1234);

      // Load r3 (lat 2) then addu r4,r3,r0 with r3 arriving on port 1.
      instr(1, 5'd0, 0, 5'd0, 1, 5'd3, 2, 8'h23);
      step();
      instr(1, 5'd3, 1, 5'd0, 1, 5'd4, 0, 8'h21);
      set_fwd(1, 1, 5'd3, 32'hCAFE);
      wait_issue("load_use", 2);
      idle();
      check("load_use_reg1", reg1_o, 32'hCAFE);
      check("load_use_reg2", reg2_o, 32'h0);

      // Port priority on r7, and r0 never forwarded.
      instr(1, 5'd7, 1, 5'd7, 0, 5'd0, 0, 8'h21);
      set_fwd(0, 1, 5'd7, 32'h1); set_fwd(1, 1, 5'd7, 32'h2);
      wait_issue("prio", 0);
      check("prio_reg1", reg1_o, 32'h1);
      idle();
      instr(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 8'h21);
      set_fwd(0, 1, 5'd0, 32'hFF);
      wait_issue("r0", 0);
      check("r0_regs", {reg1_o, reg2_o}, '0);
      idle();

      // Back-pressure with r9 pending for 2 advances.
      instr(0, 5'd0, 0, 5'd0, 1, 5'd9, 2, 8'h23);
      step();
      instr(1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 8'h21);
      out_ready_i = 0;
      snap = slot_now();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_hazard", hazard_o, 1'b1);
         check("bp_stable", slot_now(), snap);
         step();
      end
      out_ready_i = 1;
      wait_issue("bp_release", 2);
      idle();

      // Flush keeps the scoreboard: r6 still needs 3 advances afterwards.
      instr(0, 5'd0, 0, 5'd0, 1, 5'd6, 3, 8'h23);
      step();
      instr(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 8'h21);
      flush_i = 1; out_ready_i = 0;
      @(negedge clk); check("flush_ready", in_ready_o, 1'b0);
      step();
      flush_i = 0; out_ready_i = 1;
      check("flush_valid", out_valid_o, 1'b0);
      check("flush_wreg", wreg_o, 1'b0);
      instr(1, 5'd6, 0, 5'd0, 0, 5'd0, 0, 8'h21);
      wait_issue("flush_cnt", 3);
      idle();

      // Reset mid-stream with r5 pending and a held slot.
      instr(0, 5'd0, 0, 5'd0, 1, 5'd5, 3, 8'h23);
      step();
      in_valid_i = 0; out_ready_i = 0;
      #1 rst = 1;
      #1;
      check("midrst_valid", out_valid_o, 1'b0);
      check("midrst_aluop", aluop_o, EXE_NOP_OP);
      step();
      rst = 0; out_ready_i = 1;
      instr(1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 8'h21);
      @(negedge clk);
      check("midrst_nohazard", hazard_o, 1'b0);
      check("midrst_ready", in_ready_o, 1'b1);
      step(); idle();

      repeat (400) begin
         rand_cycle();
         step();
      end
      idle();
      repeat (12) step();
      check("drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised operand-collect and issue stage between the instruction decoder and the EX stage. Holds a per-register countdown scoreboard for long-latency results such as loads and multi-cycle mul/div, and stalls a dependent instruction until its source can be forwarded. Selects each operand from N forwarding ports, the register file or the immediate. Registers the issued instruction into a valid/ready ID/EX slot.

## Interface
- `DATA_W`, 32, operand/data width (matches `RegBus`)
- `NUM_FWD`, 2, forwarding ports; index 0 is the youngest stage (EX), highest priority
- `LAT_W`, 3, width of latency field and scoreboard counters (max latency 2^LAT_W-1)
- `clk` in 1, pipeline clock
- `rst` in 1, asynchronous, active-high reset
- `flush_i` in 1, kill the held ID/EX instruction
- `in_valid_i` in 1, decoded instruction present
- `in_ready_o` out 1, instruction accepted this cycle when high with `in_valid_i`
- `rs_read_i`, `rt_read_i` in 1 each, operand comes from a register (else `imm_i`)
- `rs_addr_i`, `rt_addr_i` in 5 each, source register addresses
- `imm_i` in DATA_W, immediate/shamt operand
- `wreg_i` in 1, instruction writes `wd_i`
- `wd_i` in 5, destination register
- `lat_i` in LAT_W, back-end advance cycles after issue before the result appears on a forwarding port
- `aluop_i` in 8, `alusel_i` in 3, pass-through opcode fields
- `rs_data_i`, `rt_data_i` in DATA_W, register file read data
- `fwd_we_i` in NUM_FWD, per-port write enable
- `fwd_addr_i` in 5*NUM_FWD, per-port destination, port k at [5k+4:5k]
- `fwd_data_i` in DATA_W*NUM_FWD, per-port result
- `out_valid_o` out 1, `out_ready_i` in 1, ID/EX handshake
- `reg1_o`, `reg2_o` out DATA_W, resolved operands
- `aluop_o`, `alusel_o`, `wd_o`, `wreg_o` out, registered pass-through
- `hazard_o` out 1, high when `in_valid_i` is blocked by the scoreboard

## Operation
- Scoreboard: `cnt[r]` for r=1..31. `cnt[0]` is hard-wired 0.
- `adv` is `out_ready_i`. On each `adv` cycle every nonzero counter decrements by 1.
- Issue: `cnt[wd_i] <= max(cnt[wd_i]-adv, lat_i)` when accepted with `wreg_i=1` and `wd_i!=0`. This covers WAW and simultaneous set/decrement.
- Hazard exists when (`rs_read_i` and `cnt[rs_addr_i]!=0`) or (`rt_read_i` and `cnt[rt_addr_i]!=0`).
- Ready equation: `in_ready_o = !flush_i & !hazard & (!out_valid_o | out_ready_i)`.
- Operand select for reg1, with reg2 symmetric on rt:
  - If `!rs_read_i`, use `imm_i`.
  - Else if addr==0, use 0.
  - Else use the lowest-index port k with `fwd_we_i[k]` and an address match.
  - Else use `rs_data_i`.
- Accept loads the output slot and sets `out_valid_o=1`.
- `out_valid_o` clears on `out_ready_i` when there is no new accept.
- A held slot is stable while `out_valid_o & !out_ready_i`.
- `flush_i` clears `out_valid_o` and `wreg_o` next edge and blocks accept that cycle.
- Scoreboard is not cleared by flush. A stale count costs at most 2^LAT_W-1 extra stall cycles and is never incorrect.

## Timing
- Accept to `out_valid_o`: 1 cycle. Operands are sampled at the accept edge.
- `in_ready_o`, `hazard_o` and operand mux are combinational from inputs and state.
- Dependent issue with `lat_i=0`: back-to-back, no bubble, value forwarded.
- Dependent issue with `lat_i=L`: L bubbles, given `out_ready_i` held high.
- Reset (async assert, state at value immediately):
  - all `cnt` = 0, `out_valid_o` = 0, `wreg_o` = 0
  - `reg1_o`, `reg2_o` = 0, `wd_o` = 0
  - `aluop_o` = `EXE_NOP_OP`, `alusel_o` = `EXE_RES_NOP`
- Reset mid-stall discards the held instruction and all pending counts.
- Back-pressure (`out_ready_i=0`) freezes counters and the output slot.

## Structure
- `EXE_*_OP`, `EXE_RES_*`, `RegAddrBus`, `ZeroWord` and `NOPRegAddr` stay in `define.v`.
- Add `` `LatBus `` there as well.
- Sub-module `fwd_mux`, instantiated twice (rs, rt). It handles the NUM_FWD priority match, the regfile fallback and imm/zero selection.
- Scoreboard counters and handshake live in the top.

## Test plan
- Reset mid-stream: assert `rst` with `cnt[5]=3` and `out_valid_o=1`. Required: immediately `out_valid_o=0` and `aluop_o=EXE_NOP_OP`, and after release a reader of r5 issues with no stall.
- `ori r1` (lat 0) then `or r2,r1,r1`, with fwd port0 = {we=1, addr=1, data=0x1234}. Required: both accepted consecutively, second `reg1_o=reg2_o=0x1234`.
- Load r3 with lat=2, then `addu r4,r3,r0`. Required: `hazard_o=1` for 2 cycles, accept on 3rd, with port1 data 0xCAFE forwarded.
- Ports 0 and 1 both write r7, with 0x1 and 0x2. Required: operand = 0x1. Reads of r0 with port0 addr=0 and data 0xFF give 0.
- `out_ready_i=0` for 4 cycles with `cnt[9]=2`. Required: `cnt[9]` stays 2 and `out_*` is stable; after release, a reader of r9 waits exactly 2 cycles.
- `flush_i` with `in_valid_i=1`. Required: `in_ready_o=0` and `out_valid_o=0` next cycle; prior `cnt` values are unchanged.
